// File: rtl/dds_spi_writer.sv
// AD9910 register writer: serialises one instruction byte plus 1..4 data bytes
// per accepted 64-bit word on a mode-0 SPI port, then optionally pulses IO_UPDATE.
module dds_spi_writer #(
    parameter int CLK_DIV     = 4,
    parameter int IOUPD_WIDTH = 8
) (
    input  logic        CLK100MHZ,
    input  logic        reset,
    input  logic        start,
    input  logic [63:0] data_in,
    output logic        busy,
    output logic        done,
    output logic        cs_n,
    output logic        sclk,
    output logic        sdio,
    output logic        io_update,
    output logic        start_dropped
);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD, IOUPD} state_t;

    localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
    localparam logic [7:0] IOUPD_LAST = 8'(IOUPD_WIDTH - 1);

    state_t      state;
    logic [39:0] shreg;
    logic [7:0]  div_cnt;
    logic [5:0]  bit_cnt;
    logic [5:0]  last_bit;
    logic [7:0]  iou_cnt;
    logic        upd_req;
    logic [39:0] frame;
    logic [5:0]  frame_last;
    logic        unused_bits;

    assign unused_bits = ^data_in[52:32];

    // Instruction byte followed by the N selected data bytes, left-aligned in 40 bits
    always_comb begin
        frame = '0;
        case (data_in[55:54])
            2'd0:    frame = {data_in[63:56], data_in[7:0],  24'd0};
            2'd1:    frame = {data_in[63:56], data_in[15:0], 16'd0};
            2'd2:    frame = {data_in[63:56], data_in[23:0], 8'd0};
            default: frame = {data_in[63:56], data_in[31:0]};
        endcase
        frame_last = {1'b0, data_in[55:54], 3'b000} + 6'd15;
    end

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            cs_n          <= 1'b1;
            sclk          <= 1'b0;
            sdio          <= 1'b0;
            io_update     <= 1'b0;
            start_dropped <= 1'b0;
            shreg         <= '0;
            div_cnt       <= '0;
            bit_cnt       <= '0;
            last_bit      <= '0;
            iou_cnt       <= '0;
            upd_req       <= 1'b0;
        end else begin
            done          <= 1'b0;
            start_dropped <= start && (state != IDLE);
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= SHIFT;
                        busy     <= 1'b1;
                        cs_n     <= 1'b0;
                        sclk     <= 1'b0;
                        sdio     <= data_in[63];
                        shreg    <= frame;
                        last_bit <= frame_last;
                        upd_req  <= data_in[53];
                        div_cnt  <= '0;
                        bit_cnt  <= '0;
                    end
                end
                SHIFT: begin
                    if (div_cnt != DIV_LAST) begin
                        div_cnt <= div_cnt + 8'd1;
                    end else begin
                        div_cnt <= '0;
                        if (!sclk) begin
                            sclk <= 1'b1;
                        end else begin
                            sclk <= 1'b0;
                            // New data only on the falling edge, so the DDS sees it stable at the rise
                            if (bit_cnt == last_bit) begin
                                state <= HOLD;
                            end else begin
                                bit_cnt <= bit_cnt + 6'd1;
                                shreg   <= {shreg[38:0], 1'b0};
                                sdio    <= shreg[38];
                            end
                        end
                    end
                end
                HOLD: begin
                    if (div_cnt != DIV_LAST) begin
                        div_cnt <= div_cnt + 8'd1;
                    end else begin
                        div_cnt <= '0;
                        cs_n    <= 1'b1;
                        sdio    <= 1'b0;
                        if (upd_req) begin
                            state     <= IOUPD;
                            io_update <= 1'b1;
                            iou_cnt   <= '0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                IOUPD: begin
                    if (iou_cnt != IOUPD_LAST) begin
                        iou_cnt <= iou_cnt + 8'd1;
                    end else begin
                        state     <= IDLE;
                        io_update <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dds_spi_writer.sv
// Bench for dds_spi_writer: a cycle-timeline model derived from frame length and
// bit position is compared against every output each cycle, plus directed frames.
module tb_dds_spi_writer;

    localparam int CLK_DIV     = 2;
    localparam int IOUPD_WIDTH = 8;

    logic        CLK100MHZ = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [63:0] data_in = '0;
    logic        busy, done, cs_n, sclk, sdio, io_update, start_dropped;

    dds_spi_writer #(.CLK_DIV(CLK_DIV), .IOUPD_WIDTH(IOUPD_WIDTH)) dut (
        .CLK100MHZ    (CLK100MHZ),
        .reset        (reset),
        .start        (start),
        .data_in      (data_in),
        .busy         (busy),
        .done         (done),
        .cs_n         (cs_n),
        .sclk         (sclk),
        .sdio         (sdio),
        .io_update    (io_update),
        .start_dropped(start_dropped)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a transfer is a timeline of m_len busy cycles; outputs follow from the cycle index
    int   m_t = -1;
    int   m_len = 0;
    int   m_nb = 0;
    int   m_n = 0;
    int   m_s = 0;
    logic m_upd = 1'b0;
    logic m_bits [0:39];
    bit   model_valid = 0;
    logic e_busy, e_done, e_cs_n, e_sclk, e_sdio, e_io, e_drop;
    bit   e_sdio_care;

    always @(posedge CLK100MHZ) begin
        model_valid = 1;
        e_done = 1'b0;
        e_drop = 1'b0;
        if (reset) begin
            m_t = -1;
        end else if (m_t < 0) begin
            if (start) begin
                m_n   = int'(data_in[55:54]) + 1;
                m_nb  = 8 + 8 * m_n;
                m_upd = data_in[53];
                for (int k = 0; k < 8; k++) m_bits[k] = data_in[63 - k];
                for (int k = 0; k < 8 * m_n; k++) m_bits[8 + k] = data_in[8 * m_n - 1 - k];
                m_len = 2 * CLK_DIV * m_nb + CLK_DIV + (m_upd ? IOUPD_WIDTH : 0);
                m_t   = 0;
            end
        end else begin
            e_drop = start;
            m_t++;
            if (m_t == m_len) begin
                m_t = -1;
                e_done = 1'b1;
            end
        end
        e_busy = (m_t >= 0);
        e_cs_n = 1'b1;
        e_sclk = 1'b0;
        e_sdio = 1'b0;
        e_io   = 1'b0;
        e_sdio_care = 1;
        if (m_t >= 0) begin
            m_s = 2 * CLK_DIV * m_nb;
            if (m_t < m_s) begin
                e_cs_n = 1'b0;
                e_sclk = (m_t % (2 * CLK_DIV)) >= CLK_DIV;
                e_sdio = m_bits[m_t / (2 * CLK_DIV)];
            end else if (m_t < m_s + CLK_DIV) begin
                e_cs_n = 1'b0;
                e_sdio_care = 0;
            end else begin
                e_io = 1'b1;
            end
        end
    end

    always @(negedge CLK100MHZ) begin
        if (model_valid) begin
            checkOutput("busy", busy, e_busy);
            checkOutput("done", done, e_done);
            checkOutput("cs_n", cs_n, e_cs_n);
            checkOutput("sclk", sclk, e_sclk);
            checkOutput("io_update", io_update, e_io);
            checkOutput("start_dropped", start_dropped, e_drop);
            if (e_sdio_care) checkOutput("sdio", sdio, e_sdio);
        end
    end

    // Wire-level monitor: what a DDS would see on the pins
    logic        prev_sclk = 1'b0, prev_cs_n = 1'b1, prev_busy = 1'b0;
    logic [63:0] cap_val = '0;
    int cap_bits = 0, busy_run = 0, busy_len = 0, cs_high_run = 0, last_gap = 0;
    int io_total = 0, done_total = 0, drop_total = 0;

    always @(negedge CLK100MHZ) begin
        if (prev_cs_n && !cs_n) begin
            cap_val  = '0;
            cap_bits = 0;
            last_gap = cs_high_run;
        end
        if (!cs_n && sclk && !prev_sclk) begin
            cap_val = {cap_val[62:0], sdio};
            cap_bits++;
        end
        if (busy) busy_run++;
        else if (prev_busy) begin
            busy_len = busy_run;
            busy_run = 0;
        end
        cs_high_run = cs_n ? cs_high_run + 1 : 0;
        if (io_update) io_total++;
        if (done) done_total++;
        if (start_dropped) drop_total++;
        prev_sclk = sclk;
        prev_cs_n = cs_n;
        prev_busy = busy;
    end

    int io0, done0, drop0;

    task automatic snap();
        io0 = io_total;
        done0 = done_total;
        drop0 = drop_total;
    endtask

    task automatic applyStimulus(input logic [63:0] word);
        start   = 1'b1;
        data_in = word;
        @(negedge CLK100MHZ); #1;
        start = 1'b0;
    endtask

    task automatic waitIdle();
        int n;
        for (n = 0; n < 2000; n++) begin
            if (busy === 1'b0) break;
            @(negedge CLK100MHZ); #1;
        end
        if (n == 2000) checkOutput("idle_timeout", busy, 1'b0);
        repeat (2) @(negedge CLK100MHZ);
        #1;
    endtask

    task automatic checkFrame(input string name, input logic [63:0] exp_val, input int exp_bits,
                              input int exp_busy, input int exp_io, input int exp_drop);
        checkOutput({name, "_bits"}, cap_val, exp_val);
        checkOutput({name, "_nrise"}, cap_bits, exp_bits);
        checkOutput({name, "_busy_len"}, busy_len, exp_busy);
        checkOutput({name, "_io_len"}, io_total - io0, exp_io);
        checkOutput({name, "_done_cnt"}, done_total - done0, 1);
        checkOutput({name, "_drop_cnt"}, drop_total - drop0, exp_drop);
    endtask

    localparam logic [63:0] W1 = 64'h0000_0000_0000_00A5;
    localparam logic [63:0] W2 = 64'h0EC0_0000_DEAD_BEEF;
    localparam logic [63:0] W3 = 64'h0160_0000_0000_1234;

    initial begin
        int n;
        repeat (2) @(negedge CLK100MHZ);
        #1;
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_cs_n", cs_n, 1'b1);
        checkOutput("rst_sclk", sclk, 1'b0);
        checkOutput("rst_sdio", sdio, 1'b0);
        checkOutput("rst_io", io_update, 1'b0);
        checkOutput("rst_drop", start_dropped, 1'b0);
        reset = 1'b0;
        repeat (2) @(negedge CLK100MHZ);
        #1;

        $display("[TB] single-byte frame");
        snap(); applyStimulus(W1); waitIdle();
        checkFrame("t1", 64'h00A5, 16, 66, 0, 0);

        $display("[TB] four-byte frame");
        snap(); applyStimulus(W2); waitIdle();
        checkFrame("t2", 64'h0E_DEAD_BEEF, 40, 162, 0, 0);

        $display("[TB] two-byte frame with IO_UPDATE");
        snap(); applyStimulus(W3); waitIdle();
        checkFrame("t3", 64'h01_1234, 24, 106, IOUPD_WIDTH, 0);

        $display("[TB] start while busy");
        snap(); applyStimulus(W1);
        repeat (20) @(negedge CLK100MHZ);
        #1;
        applyStimulus(64'hFFFF_FFFF_FFFF_FFFF);
        waitIdle();
        checkFrame("t4", 64'h00A5, 16, 66, 0, 1);

        $display("[TB] start in the done cycle");
        applyStimulus(W1);
        for (n = 0; n < 1000; n++) begin
            if (done === 1'b1) break;
            @(negedge CLK100MHZ); #1;
        end
        if (n == 1000) checkOutput("done_timeout", done, 1'b1);
        checkOutput("t5_first_busy_len", busy_len, 66);
        snap(); applyStimulus(W2); waitIdle();
        checkOutput("t5_gap_ok", last_gap >= 1, 1'b1);
        checkFrame("t5", 64'h0E_DEAD_BEEF, 40, 162, 0, 0);

        $display("[TB] reset during shift");
        snap(); applyStimulus(W2);
        for (n = 0; n < 1000; n++) begin
            if (cap_bits == 10) break;
            @(negedge CLK100MHZ); #1;
        end
        if (n == 1000) checkOutput("bit10_timeout", cap_bits, 10);
        reset = 1'b1;
        @(negedge CLK100MHZ); #1;
        checkOutput("t6_cs_n", cs_n, 1'b1);
        checkOutput("t6_sclk", sclk, 1'b0);
        checkOutput("t6_busy", busy, 1'b0);
        reset = 1'b0;
        repeat (20) @(negedge CLK100MHZ);
        #1;
        checkOutput("t6_no_done", done_total - done0, 0);
        checkOutput("t6_no_io", io_total - io0, 0);
        snap(); applyStimulus(W3); waitIdle();
        checkFrame("t6b", 64'h01_1234, 24, 106, IOUPD_WIDTH, 0);

        $display("[TB] randomized traffic");
        for (int c = 0; c < 4000; c++) begin
            start   = ($urandom_range(0, 11) == 0);
            data_in = {$urandom, $urandom};
            reset   = ($urandom_range(0, 1499) == 0);
            @(negedge CLK100MHZ); #1;
        end
        start = 1'b0;
        reset = 1'b0;
        waitIdle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        errors++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dds_spi_writer.md
Name: dds_spi_writer

Overview:
- Downstream consumer of the GPO core's 64-bit output word. It serialises one AD9910 register write per accepted word onto the DDS SPI pins (CS_N, SCLK, SDIO), with an optional IO_UPDATE pulse afterwards.
- Its busy output feeds the GPO core's busy input. A word presented while busy is therefore flagged upstream as a busy error, not lost silently.

Parameters:
- CLK_DIV, 4: SCLK half-period in CLK100MHZ cycles; must be ≥1.
- IOUPD_WIDTH, 8: IO_UPDATE high time in cycles; must be ≥1.

Ports:
- CLK100MHZ  input  1  system clock
- reset  input  1  synchronous, active-high
- start  input  1  one-cycle strobe; driven by the GPO core's selected output
- data_in  input  64  word from the GPO core's gpo_out; fields defined under Behaviour
- busy  output  1  high from the cycle after an accepted start until the return to IDLE
- done  output  1  one-cycle pulse on the return to IDLE
- cs_n  output  1  SPI chip select, active low
- sclk  output  1  SPI clock, mode 0
- sdio  output  1  SPI data, MSB first
- io_update  output  1  AD9910 IO_UPDATE
- start_dropped  output  1  one-cycle pulse when start arrives while busy

Behaviour:
- Reset values: busy=0, done=0, cs_n=1, sclk=0, sdio=0, io_update=0, start_dropped=0. State is IDLE.
- Reset mid-transfer aborts. On the next edge all outputs return to reset values, with no IO_UPDATE and no done.
- data_in fields:
  - [63:56] instruction byte, sent verbatim (bit7 = R/W, write = 0).
  - [55:54] length code L; number of data bytes N = L+1 (1..4).
  - [53] io_update request.
  - [31:0] data; the bytes sent are data_in[8N-1:0], MSB first.
  - All other bits are ignored.
- Bits per transfer: NB = 8 + 8N. The shift register is 40 bits, left-aligned on capture.
- Accept: start=1 in IDLE captures data_in that cycle. At the next edge:
  - state goes to SHIFT;
  - busy=1, cs_n=0, sclk=0;
  - sdio = instruction bit 7.
- SHIFT, per bit:
  - sclk low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - sdio changes only at the high-to-low SCLK transition, and at entry. The DDS samples on the rising edge.
  - A bit counter counts NB bits. After the high phase of the last bit, go to HOLD with sclk=0.
- HOLD: cs_n stays low for CLK_DIV cycles. Then cs_n=1 and sdio=0. Next state is IOUPD if the request bit was set, otherwise IDLE.
- IOUPD: io_update=1 for exactly IOUPD_WIDTH cycles, then IDLE.
- Entering IDLE: busy=0 and done=1 for one cycle.
- Busy length: 2·CLK_DIV·NB + CLK_DIV (+ IOUPD_WIDTH if requested) cycles.
- start while busy=1: ignored and start_dropped pulses. The transfer in progress is unaffected.
- start in the same cycle done pulses: state is already IDLE, so the word is accepted. Back-to-back transfers are legal, with cs_n high for at least one cycle between them.
- Counters are sized for CLK_DIV up to 255 and IOUPD_WIDTH up to 255.

Test Plan:
- Reset check → all outputs at reset values. Start with CLK_DIV=2, data_in=0x0000_0000_0000_00A5 (instr 0x00, N=1) → on SDIO, 16 bits 0x00A5 MSB first, sampled on each SCLK rise; busy high for 66 cycles; io_update never high; done pulses once.
- data_in=0x0EC0_0000_DEAD_BEEF (instr 0x0E, L=3, no update) → 40 bits 0x0E_DEADBEEF on SDIO; exactly 40 SCLK rising edges while cs_n=0.
- data_in=0x0160_0000_0000_1234 (instr 0x01, N=2, io_update) → 24 bits 0x01_1234; after cs_n rises, io_update high exactly IOUPD_WIDTH=8 cycles; busy drops on the same edge io_update falls.
- Start re-asserted mid-transfer → start_dropped pulses; SDIO stream bit-identical to the undisturbed case. Start asserted in the done cycle → second transfer begins, with cs_n high for at least one cycle between the transfers.
- Reset asserted mid-SHIFT at bit 10 → next cycle cs_n=1, sclk=0, busy=0; no done; no io_update. A following start produces a complete, correct frame.
- Integration with the GPO core: two words with matching destination, 3 cycles apart → first transmitted; second raises the GPO core's busy_error with its data in error_data.
